// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: HD44780 init then endless 2x16 refresh from a text source.
// Define LCD_4BIT_EN for 4-bit bus mode (nibbles on lcd_data[7:4]).
module lcd_refresh_ctrl #(
  parameter int T_POWERUP = 2000000,
  parameter int T_SETUP   = 5,
  parameter int T_E_HIGH  = 25,
  parameter int T_CMD     = 5000,
  parameter int T_CLEAR   = 200000,
  parameter int T_SETTLE  = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] addr,
  input  logic [7:0] ascii,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       frame_done
);
  localparam int MAXD = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
  localparam int CW = $clog2(MAXD + 1);
`ifdef LCD_4BIT_EN
  localparam bit FOUR  = 1'b1;
  localparam int NINIT = 8;
`else
  localparam bit FOUR  = 1'b0;
  localparam int NINIT = 4;
`endif

  typedef enum logic [2:0] {
    PWRUP, INIT, LINE, FETCH, SETUP, EHIGH, WAIT
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt, w_last;
  logic [4:0]    r_addr, w_addr, r_pos, w_pos;
  logic [2:0]    r_idx, w_idx;
  logic          r_init, w_init;
  logic          r_rs, w_rs, r_e, w_e, r_fd, w_fd;
  logic [7:0]    r_data, w_data, r_byte, w_byte;
  logic          r_two, w_two, r_clr, w_clr;
  logic [8:0]    w_cmd;
  logic          w_end;

  // {full byte, value}; single nibbles sit in the low nibble
  function automatic logic [8:0] init_cmd(input logic [2:0] i);
`ifdef LCD_4BIT_EN
    unique case (i)
      3'd0, 3'd1, 3'd2: init_cmd = 9'h003;
      3'd3:             init_cmd = 9'h002;
      3'd4:             init_cmd = 9'h128;
      3'd5:             init_cmd = 9'h10C;
      3'd6:             init_cmd = 9'h106;
      default:          init_cmd = 9'h101;
    endcase
`else
    unique case (i)
      3'd0:    init_cmd = 9'h138;
      3'd1:    init_cmd = 9'h10C;
      3'd2:    init_cmd = 9'h106;
      default: init_cmd = 9'h101;
    endcase
`endif
  endfunction

  function automatic logic [7:0] pin(input logic [7:0] b,
                                     input logic hi);
    if (FOUR) pin = hi ? {b[7:4], 4'h0} : {b[3:0], 4'h0};
    else      pin = b;
  endfunction

  always_comb begin
    w_last = '0;
    unique case (r_state)
      PWRUP:   w_last = CW'(T_POWERUP - 1);
      FETCH:   w_last = CW'(T_SETTLE - 1);
      SETUP:   w_last = CW'(T_SETUP - 1);
      EHIGH:   w_last = CW'(T_E_HIGH - 1);
      WAIT:    w_last = (r_clr && !r_two) ? CW'(T_CLEAR - 1)
                                          : CW'(T_CMD - 1);
      default: w_last = '0;
    endcase
  end

  assign w_end = (r_cnt == w_last);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + 1'b1;
    w_addr  = r_addr;
    w_pos   = r_pos;
    w_idx   = r_idx;
    w_init  = r_init;
    w_rs    = r_rs;
    w_e     = r_e;
    w_fd    = 1'b0;
    w_data  = r_data;
    w_byte  = r_byte;
    w_two   = r_two;
    w_clr   = r_clr;
    w_cmd   = init_cmd(r_idx);
    unique case (r_state)
      PWRUP: if (w_end) begin
        w_state = INIT;
        w_cnt   = '0;
        w_idx   = '0;
        w_init  = 1'b1;
        w_pos   = '0;
      end
      INIT: begin
        w_state = SETUP;
        w_cnt   = '0;
        w_rs    = 1'b0;
        w_byte  = w_cmd[7:0];
        w_two   = FOUR && w_cmd[8];
        w_clr   = (w_cmd[7:0] == 8'h01);
        w_data  = pin(w_cmd[7:0], FOUR && w_cmd[8]);
      end
      LINE: begin
        w_state = SETUP;
        w_cnt   = '0;
        w_rs    = 1'b0;
        w_byte  = r_pos[4] ? 8'hC0 : 8'h80;
        w_two   = FOUR;
        w_clr   = 1'b0;
        w_data  = pin(w_byte, FOUR);
      end
      FETCH: if (w_end) begin
        w_state = SETUP;
        w_cnt   = '0;
        w_rs    = 1'b1;
        w_byte  = ascii;
        w_two   = FOUR;
        w_clr   = 1'b0;
        w_data  = pin(ascii, FOUR);
      end
      SETUP: if (w_end) begin
        w_state = EHIGH;
        w_cnt   = '0;
        w_e     = 1'b1;
      end
      EHIGH: if (w_end) begin
        w_state = WAIT;
        w_cnt   = '0;
        w_e     = 1'b0;
      end
      WAIT: if (w_end) begin
        w_cnt = '0;
        if (r_two) begin
          w_state = SETUP;
          w_two   = 1'b0;
          w_data  = pin(r_byte, 1'b0);
        end else if (r_init) begin
          if (r_idx == 3'(NINIT - 1)) begin
            w_state = LINE;
            w_init  = 1'b0;
          end else begin
            w_state = INIT;
            w_idx   = r_idx + 1'b1;
          end
        end else if (r_rs) begin
          w_pos   = r_addr + 1'b1;
          w_fd    = (r_addr == 5'd31);
          w_state = (r_addr[3:0] == 4'hF) ? LINE : FETCH;
          if (r_addr[3:0] != 4'hF) w_addr = r_addr + 1'b1;
        end else begin
          w_state = FETCH;
          w_addr  = r_pos;
        end
      end
      default: w_state = PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= PWRUP;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_pos   <= '0;
      r_idx   <= '0;
      r_init  <= 1'b0;
      r_rs    <= 1'b0;
      r_e     <= 1'b0;
      r_fd    <= 1'b0;
      r_data  <= 8'h00;
      r_byte  <= 8'h00;
      r_two   <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_pos   <= w_pos;
      r_idx   <= w_idx;
      r_init  <= w_init;
      r_rs    <= w_rs;
      r_e     <= w_e;
      r_fd    <= w_fd;
      r_data  <= w_data;
      r_byte  <= w_byte;
      r_two   <= w_two;
      r_clr   <= w_clr;
    end
  end

  assign addr       = r_addr;
  assign lcd_rs     = r_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = r_e;
  assign lcd_data   = r_data;
  assign frame_done = r_fd;
endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb_lcd_refresh_ctrl: checks E-pulse sequence, timing and frame_done
// of lcd_refresh_ctrl against a transfer-list model.
module tb_lcd_refresh_ctrl;
  localparam int TP  = 10;
  localparam int TS  = 2;
  localparam int TE  = 3;
  localparam int TC  = 4;
  localparam int TCL = 8;
  localparam int TST = 2;
`ifdef LCD_4BIT_EN
  localparam bit FOUR = 1'b1;
`else
  localparam bit FOUR = 1'b0;
`endif
  localparam int BW = FOUR ? 2 : 1;
  localparam int NI = FOUR ? 12 : 4;
  localparam int PF = 34 * BW;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] addr;
  logic [7:0] ascii;
  logic       lcd_rs, lcd_rw, lcd_e, frame_done;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_refresh_ctrl #(
    .T_POWERUP(TP), .T_SETUP(TS), .T_E_HIGH(TE),
    .T_CMD(TC), .T_CLEAR(TCL), .T_SETTLE(TST)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .ascii(ascii),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_data(lcd_data), .frame_done(frame_done)
  );

  typedef struct packed {
    bit       rs;
    bit [7:0] data;
    int       len;
    int       gap;
    int       stab;
    bit       unstable;
    int       fd;
  } pulse_t;

  typedef struct packed {
    bit       rs;
    bit [7:0] data;
  } xfer_t;

  pulse_t     q[$];
  xfer_t      exp_q[$];
  logic [7:0] tbl[32];
  bit         amode = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         fd_cnt = 0, fd_bad = 0, rw_bad = 0;
  int         lo_bad = 0, hold_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // expected transfers, one entry per E pulse
  task automatic push_byte(input bit rs, input logic [7:0] b);
    xfer_t x;
    x.rs = rs;
    if (FOUR) begin
      x.data = {b[7:4], 4'h0};
      exp_q.push_back(x);
      x.data = {b[3:0], 4'h0};
      exp_q.push_back(x);
    end else begin
      x.data = b;
      exp_q.push_back(x);
    end
  endtask

  task automatic push_nib(input logic [3:0] n);
    xfer_t x;
    x.rs = 1'b0;
    x.data = {n, 4'h0};
    exp_q.push_back(x);
  endtask

  task automatic push_init();
    if (FOUR) begin
      push_nib(4'h3); push_nib(4'h3); push_nib(4'h3); push_nib(4'h2);
      push_byte(1'b0, 8'h28);
    end else begin
      push_byte(1'b0, 8'h38);
    end
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h01);
  endtask

  task automatic push_frame(input bit rnd);
    push_byte(1'b0, 8'h80);
    for (int a = 0; a < 32; a++) begin
      if (a == 16) push_byte(1'b0, 8'hC0);
      push_byte(1'b1, rnd ? tbl[a] : 8'(8'h41 + a));
    end
  endtask

  task automatic wait_pulses(input int n);
    int k = 0;
    while (q.size() < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("pulse_timeout", 32'(q.size() >= n), 1);
  endtask

  task automatic chk_pulses(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      chk($sformatf("p%0d_rs", i), q[i].rs, exp_q[i].rs);
      chk($sformatf("p%0d_data", i), q[i].data, exp_q[i].data);
      chk($sformatf("p%0d_ehigh", i), q[i].len, TE);
      chk($sformatf("p%0d_stable", i), q[i].unstable, 0);
      chk($sformatf("p%0d_setup", i), 32'(q[i].stab >= TS), 1);
      if (i > 0)
        chk($sformatf("p%0d_gap", i), 32'(q[i].gap >= TC + TS), 1);
    end
  endtask

  task automatic count_low(input string tag);
    int lowc = 0;
    while (!lcd_e && lowc < 200) begin
      @(negedge clk);
      if (!lcd_e) lowc++;
    end
    chk({tag, "_min"}, 32'(lowc >= TP + TS), 1);
    chk({tag, "_max"}, 32'(lowc <= TP + TS + 4), 1);
  endtask

  // ascii source: good value only for the sample edge in random mode
  initial begin : drv
    logic [4:0] pa;
    int m;
    pa = '0;
    m = 0;
    ascii = 8'h00;
    forever begin
      @(negedge clk);
      if (addr !== pa) m = 0;
      else m++;
      pa = addr;
      if (!amode) ascii = 8'h41 + {3'b000, addr};
      else if (m + 1 == TST) ascii = tbl[addr];
      else ascii = 8'($urandom);
    end
  end

  initial begin : mon
    pulse_t cur;
    bit prev_e, prev_fd, have_pulse, chg;
    logic [8:0] prev_rd;
    int low_run, stab, since_fall;
    cur = '0;
    prev_e = 1'b0; prev_fd = 1'b0; have_pulse = 1'b0;
    prev_rd = '0;
    low_run = 0; stab = 0; since_fall = 0;
    forever begin
      @(negedge clk);
      chg = ({lcd_rs, lcd_data} !== prev_rd);
      if (lcd_rw !== 1'b0) rw_bad++;
      if (FOUR && lcd_data[3:0] !== 4'h0) lo_bad++;
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (addr !== 5'd31 || lcd_rs !== 1'b1 || lcd_e || prev_fd)
          fd_bad++;
      end
      if (lcd_e && !prev_e) begin
        cur.rs = lcd_rs;
        cur.data = lcd_data;
        cur.len = 1;
        cur.gap = low_run;
        cur.stab = chg ? 0 : stab;
        cur.unstable = 1'b0;
        cur.fd = fd_cnt;
      end else if (lcd_e) begin
        cur.len++;
        if (lcd_rs !== cur.rs || lcd_data !== cur.data)
          cur.unstable = 1'b1;
      end else if (prev_e) begin
        q.push_back(cur);
        have_pulse = 1'b1;
        since_fall = 0;
      end
      if (!lcd_e) begin
        if (chg && have_pulse && since_fall < TC) hold_bad++;
        since_fall++;
        stab = chg ? 1 : stab + 1;
        low_run++;
      end else begin
        low_run = 0;
      end
      prev_e = lcd_e;
      prev_fd = frame_done;
      prev_rd = {lcd_rs, lcd_data};
    end
  end

  initial begin : main
    int k;
    for (int i = 0; i < 32; i++) tbl[i] = 8'($urandom);
    tbl[5] = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_addr", addr, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_rw", lcd_rw, 0);
    reset = 1'b0;
    count_low("pwrup_low");

    push_init();
    push_frame(1'b0);
    push_frame(1'b1);
    push_byte(1'b0, 8'h80);

    wait_pulses(NI + PF + BW);
    amode = 1'b1;
    chk_pulses(0, NI + PF + BW);
    chk("fd_none_in_init", q[NI].fd, 0);
    chk("fd_frame0", q[NI + PF].fd, 1);
    chk("clr_gap_diff", q[NI].gap - q[NI - BW].gap, TCL - TC);
    chk("clr_gap_min", 32'(q[NI].gap >= TCL + TS), 1);

    wait_pulses(NI + 2 * PF + BW);
    amode = 1'b0;
    chk_pulses(NI + PF + BW, NI + 2 * PF + BW);
    chk("fd_frame1", q[NI + 2 * PF].fd, 2);
    chk("hold_wait", hold_bad, 0);

    k = 0;
    while (!(lcd_e && lcd_rs && addr == 5'd7) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("char7_found", 32'(k < 5000), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_e", lcd_e, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_rs", lcd_rs, 0);
    chk("mid_rst_data", lcd_data, 8'h00);
    chk("mid_rst_fd", frame_done, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    q.delete();
    exp_q.delete();
    push_init();
    push_byte(1'b0, 8'h80);
    count_low("rst_pwrup_low");
    wait_pulses(NI + BW);
    chk_pulses(0, NI + BW);

    chk("rw_zero", rw_bad, 0);
    chk("lo_nibble_zero", lo_bad, 0);
    chk("fd_shape", fd_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lcd_refresh_ctrl.md
LCD_REFRESH_CTRL -- requirements
Module: lcd_refresh_ctrl

Interface
REQ-001 Parameter T_POWERUP, default 2000000, clk cycles to wait after reset before the first command (20 ms at 100 MHz).
REQ-002 Parameter T_SETUP, default 5, clk cycles that RS/data are stable with E low before E rises.
REQ-003 Parameter T_E_HIGH, default 25, clk cycles that E is held high.
REQ-004 Parameter T_CMD, default 5000, clk cycles of wait after E falls, for every transfer except clear.
REQ-005 Parameter T_CLEAR, default 200000, clk cycles of wait after E falls, for the clear command (0x01).
REQ-006 Parameter T_SETTLE, default 2, clk cycles from an addr change to the ascii sample (covers the synchronous RAM read plus the combinational path).
REQ-007 clk  in  1  system clock.
REQ-008 reset  in  1  reset (reset reset, synchronous, active-high; clock clk).
REQ-009 addr  out  5  character position requested from the text source; [4] = row, [3:0] = column.
REQ-010 ascii  in  8  character code returned for addr.
REQ-011 lcd_rs  out  1  HD44780 register select; 0 = command, 1 = data.
REQ-012 lcd_rw  out  1  HD44780 read/write; tied 0 (write only).
REQ-013 lcd_e  out  1  HD44780 enable strobe.
REQ-014 lcd_data  out  8  HD44780 data bus.
REQ-015 frame_done  out  1  one-cycle pulse after the 32nd character of a frame completes its wait.

Function
REQ-016 The block SHALL implement an FSM with states: PWRUP, INIT, LINE, FETCH, SETUP, EHIGH, WAIT.
REQ-017 PWRUP: count T_POWERUP cycles, then go to INIT with init index = 0.
REQ-018 INIT: issue commands in order, one per transfer, RS = 0: 0x38, 0x0C, 0x06, 0x01.
REQ-019 After init, the refresh loop SHALL run forever: command 0x80 (line 0); data at addr 0..15; command 0xC0 (line 1); data at addr 16..31; repeat.
REQ-020 FETCH: drive addr, wait T_SETTLE cycles, then latch ascii into lcd_data with RS = 1.
REQ-021 Transfer timing: SETUP holds for T_SETUP cycles with E = 0; EHIGH holds for T_E_HIGH cycles with E = 1; WAIT then lasts T_CMD cycles (T_CLEAR after 0x01).
REQ-022 lcd_rs and lcd_data SHALL NOT change from SETUP entry until WAIT exit.
REQ-023 addr SHALL change only on FETCH entry; addr wraps 31 -> 0 at frame end.
REQ-024 frame_done SHALL pulse in the cycle WAIT exits for addr 31; it is never asserted during init.
REQ-025 lcd_rw SHALL be 0 in every cycle.
REQ-026 A single shared delay counter, sized for max(T_POWERUP, T_CLEAR), SHALL time all states; a counter value of 0 is never used as a duration.
REQ-027 ascii SHALL be sampled exactly once per character; ascii changes at any other time are ignored.

Reset
REQ-028 While reset is high, at the clock edge: state = PWRUP, counter = 0, addr = 0, lcd_e = 0, lcd_rs = 0, lcd_rw = 0, lcd_data = 0x00, frame_done = 0.
REQ-029 Reset asserted mid-transfer (including EHIGH) SHALL drop lcd_e on the next edge and restart the full power-up and init sequence.

Configuration
REQ-030 Macro LCD_4BIT_EN:
- Defined: 4-bit bus mode.
- Each byte is sent high nibble then low nibble on lcd_data[7:4], each nibble as a full SETUP/EHIGH transfer with T_CMD spacing; lcd_data[3:0] is driven 0.
- Init becomes: nibble 0x3 three times, nibble 0x2, then bytes 0x28, 0x0C, 0x06, 0x01.
- Not defined: 8-bit mode per REQ-018.

Verification (T_POWERUP=10, T_SETUP=2, T_E_HIGH=3, T_CMD=4, T_CLEAR=8, T_SETTLE=2)
REQ-031 Release reset -> lcd_e stays 0 for 10 cycles; the first E pulse carries RS=0, data=0x38, and E is high for exactly 3 cycles.
REQ-032 Init sequence -> E-pulse data is 0x38, 0x0C, 0x06, 0x01, then 0x80; the gap after 0x01 is 8 wait cycles, after the others 4.
REQ-033 Model returns ascii = 0x41 + addr -> line 0 writes 0x41..0x50 with RS=1; then 0xC0 with RS=0; then 0x51..0x60; frame_done pulses once; the next E pulse is 0x80.
REQ-034 Toggle ascii randomly except during the T_SETTLE sample cycle -> the latched lcd_data equals the value present at the sample cycle; lcd_data is stable throughout each E-high window.
REQ-035 Assert reset for 1 cycle during EHIGH of character 7 -> lcd_e = 0 next cycle, addr = 0, and the power-up wait restarts (10 cycles).
REQ-036 With LCD_4BIT_EN, ascii = 0xA5 -> two E pulses with lcd_data[7:4] = 0xA then 0x5, and lcd_data[3:0] = 0 throughout.
